// File: rtl/ctrl_rx.sv
// rtl/ctrl_rx.sv - OCS control-frame receiver: parses 64-bit AXIS slot-ID / sim-start frames
// and emits one-cycle event pulses plus held slot ID, timestamp and source MAC to the ToR scheduler.
`timescale 1ns/1ps
module ctrl_rx #(
    parameter logic [47:0] P_MY_MAC       = 48'h8D_BC_5C_4A_00_01,
    parameter logic [47:0] P_MAC_MASK     = 48'hFF_FF_FF_FF_00_00,
    parameter logic [15:0] P_SLOT_ID_TYPE = 16'hFF03,
    parameter logic [15:0] P_SIM_START    = 16'hFF0A,
    parameter int          P_PKT_LEN      = 8,
    parameter int          P_SLOT_W       = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx_axis_tvalid,
    input  logic [63:0]         i_rx_axis_tdata,
    input  logic                i_rx_axis_tlast,
    input  logic [7:0]          i_rx_axis_tkeep,
    input  logic                i_rx_axis_tuser,
    output logic                o_rx_axis_tready,
    output logic                o_new_slot_start,
    output logic                o_sim_start,
    output logic [P_SLOT_W-1:0] o_slot_id,
    output logic [63:0]         o_time_stamp,
    output logic [47:0]         o_src_mac,
    output logic                o_frame_err,
    output logic [15:0]         o_err_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(P_PKT_LEN - 1);
    localparam logic [3:0] TS_IDX   = 4'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_DROP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                acc;
    logic [3:0]          beat_cnt;
    logic                poison_beat;
    logic                poisoned_q;
    logic                dst_hi_ok;
    logic                dst_lo_ok;
    logic                type_ok;
    logic                err_nxt;
    logic                commit;
    logic [47:0]         src_q;
    logic [15:0]         type_q;
    logic [P_SLOT_W-1:0] slot_q;
    logic [63:0]         ts_q;
    logic [63:0]         ts_commit;

    assign acc         = i_rx_axis_tvalid & o_rx_axis_tready;
    assign poison_beat = (i_rx_axis_tkeep != 8'hFF) | i_rx_axis_tuser;

    // Only the bits selected by P_MAC_MASK take part in the address match
    assign dst_hi_ok = ((i_rx_axis_tdata[15:0]  ^ P_MY_MAC[47:32]) & P_MAC_MASK[47:32]) == 16'h0;
    assign dst_lo_ok = ((i_rx_axis_tdata[63:32] ^ P_MY_MAC[31:0])  & P_MAC_MASK[31:0])  == 32'h0;
    assign type_ok   = (i_rx_axis_tdata[31:16] == P_SLOT_ID_TYPE) |
                       (i_rx_axis_tdata[31:16] == P_SIM_START);

    // With a 3-beat frame the timestamp beat is also the final beat, so bypass the latch
    assign ts_commit = (beat_cnt == TS_IDX) ? i_rx_axis_tdata : ts_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    if (!dst_hi_ok || poison_beat || i_rx_axis_tlast) begin
                        err_nxt   = 1'b1;
                        state_nxt = i_rx_axis_tlast ? S_IDLE : S_DROP;
                    end else begin
                        state_nxt = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (acc) begin
                    if (!dst_lo_ok || !type_ok || poison_beat || i_rx_axis_tlast) begin
                        err_nxt   = 1'b1;
                        state_nxt = i_rx_axis_tlast ? S_IDLE : S_DROP;
                    end else begin
                        state_nxt = S_PAY;
                    end
                end
            end
            S_PAY: begin
                if (acc) begin
                    if (i_rx_axis_tlast) begin
                        state_nxt = S_IDLE;
                        if (beat_cnt == LAST_IDX && !poisoned_q && !poison_beat) begin
                            commit = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (beat_cnt == LAST_IDX) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (acc && i_rx_axis_tlast) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rx_axis_tready <= 1'b0;
            beat_cnt         <= 4'd0;
            poisoned_q       <= 1'b0;
            src_q            <= 48'h0;
            type_q           <= 16'h0;
            slot_q           <= '0;
            ts_q             <= 64'h0;
        end else begin
            o_rx_axis_tready <= 1'b1;
            if (acc) begin
                beat_cnt <= i_rx_axis_tlast ? 4'd0 : beat_cnt + 4'd1;
            end
            // Payload poison is sticky and only reported once the frame length is known
            if (state != S_PAY) begin
                poisoned_q <= 1'b0;
            end else if (acc && poison_beat) begin
                poisoned_q <= 1'b1;
            end
            if (acc && state == S_IDLE) begin
                src_q <= i_rx_axis_tdata[63:16];
            end
            if (acc && state == S_HDR) begin
                type_q <= i_rx_axis_tdata[31:16];
                slot_q <= i_rx_axis_tdata[P_SLOT_W-1:0];
            end
            if (acc && state == S_PAY && beat_cnt == TS_IDX) begin
                ts_q <= i_rx_axis_tdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_new_slot_start <= 1'b0;
            o_sim_start      <= 1'b0;
            o_slot_id        <= '0;
            o_time_stamp     <= 64'h0;
            o_src_mac        <= 48'h0;
            o_frame_err      <= 1'b0;
            o_err_cnt        <= 16'h0;
        end else begin
            o_new_slot_start <= commit && (type_q == P_SLOT_ID_TYPE);
            o_sim_start      <= commit && (type_q == P_SIM_START);
            o_frame_err      <= err_nxt;
            if (commit) begin
                o_slot_id    <= slot_q;
                o_time_stamp <= ts_commit;
                o_src_mac    <= src_q;
            end
            if (err_nxt && o_err_cnt != 16'hFFFF) begin
                o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end

endmodule
